// File: rtl/outchars12_uart_tx_pkg.sv
// Shared constants for the 12-character UART transmitter: bit-level state encoding,
// sequencer states, frame shape and the count clamp.
package outchars12_uart_tx_pkg;

    typedef enum logic [2:0] {
        READY    = 3'd0,
        GUARD    = 3'd1,
        STARTBIT = 3'd2,
        DATA     = 3'd3,
        STOPBIT  = 3'd4
    } tx_state_e;

    // Character-level sequencer: READY, idle gap, then frames back to back.
    typedef enum logic [1:0] {
        SEQ_READY = 2'd0,
        SEQ_GUARD = 2'd1,
        SEQ_SEND  = 2'd2
    } seq_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200
    localparam int CHAR_SLOTS           = 12;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

    function automatic logic [3:0] clamp_count(input logic [3:0] cnt, input logic [3:0] lim);
        return (cnt > lim) ? lim : cnt;
    endfunction

endpackage

// File: rtl/outchars12_uart_tx_byte.sv
// Single 8N1 frame serializer. A load in the last cycle of a stop bit chains the
// next frame with no idle gap; abort drops to idle with the line high.
module uart_tx_byte
    import outchars12_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       abort_i,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       busy_o,
    output logic       frame_end_o,
    output logic       line_o
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        line_q, line_d;
    logic        tick;

    assign tick        = (baud_q == LAST);
    assign frame_end_o = (state_q == STOPBIT) && tick;
    assign busy_o      = (state_q != READY);
    assign line_o      = line_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= READY;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        baud_d  = (state_q == READY || tick) ? '0 : baud_q + 1'b1;
        if (abort_i) begin
            state_d = READY;
            baud_d  = '0;
            bit_d   = '0;
        end else if (load_i && (state_q == READY || frame_end_o)) begin
            state_d = STARTBIT;
            baud_d  = '0;
            bit_d   = '0;
            sh_d    = byte_i;
        end else if (tick) begin
            case (state_q)
                STARTBIT: state_d = DATA;
                DATA: begin
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOPBIT;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                    end
                end
                STOPBIT: state_d = READY;
                default: state_d = state_q;
            endcase
        end
    end

    // Line is registered from the next state so it always matches the current bit.
    always_comb begin
        case (state_d)
            STARTBIT: line_d = 1'b0;
            DATA:     line_d = sh_d[0];
            default:  line_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/outchars12_uart_tx.sv
// Sends c0..c(n-1) as back-to-back 8N1 frames after a one-bit-time idle guard,
// reporting completion on the start / result_ready handshake.
module outchars12_uart_tx
    import outchars12_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int MAX_CHARS    = CHAR_SLOTS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] n,
    input  logic [7:0] c0,
    input  logic [7:0] c1,
    input  logic [7:0] c2,
    input  logic [7:0] c3,
    input  logic [7:0] c4,
    input  logic [7:0] c5,
    input  logic [7:0] c6,
    input  logic [7:0] c7,
    input  logic [7:0] c8,
    input  logic [7:0] c9,
    input  logic [7:0] c10,
    input  logic [7:0] c11,
    output logic       outchan,
    output logic       result,
    output logic       result_ready
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    seq_state_e                  seq_q, seq_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [MAX_CHARS-1:0][7:0]   chars_q, chars_d;
    logic [BW-1:0]               guard_q, guard_d;
    logic                        result_q, result_d;
    logic [3:0]                  n_clamped;
    logic                        load;
    logic                        tx_busy, tx_frame_end, tx_line;

    assign n_clamped = clamp_count(n, 4'(MAX_CHARS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q    <= SEQ_READY;
            cnt_q    <= '0;
            chars_q  <= '0;
            guard_q  <= '0;
            result_q <= 1'b0;
        end else begin
            seq_q    <= seq_d;
            cnt_q    <= cnt_d;
            chars_q  <= chars_d;
            guard_q  <= guard_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        seq_d    = seq_q;
        cnt_d    = cnt_q;
        chars_d  = chars_q;
        guard_d  = guard_q;
        result_d = result_q;
        if (start) begin
            cnt_d    = n_clamped;
            chars_d  = {c11, c10, c9, c8, c7, c6, c5, c4, c3, c2, c1, c0};
            guard_d  = '0;
            result_d = (n_clamped == 4'd0);
            seq_d    = (n_clamped != 4'd0) ? SEQ_GUARD : SEQ_READY;
        end else begin
            case (seq_q)
                SEQ_GUARD: begin
                    guard_d = (guard_q == LAST) ? '0 : guard_q + 1'b1;
                    if (load) seq_d = SEQ_SEND;
                end
                SEQ_SEND: begin
                    if (tx_frame_end) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            result_d = 1'b1;
                            seq_d    = SEQ_READY;
                        end
                    end
                end
                default: seq_d = seq_q;
            endcase
            // Character handed to the serializer leaves slot 0 immediately.
            if (load) chars_d = {8'h00, chars_q[MAX_CHARS-1:1]};
        end
    end

    always_comb begin
        load = 1'b0;
        if (!start) begin
            case (seq_q)
                SEQ_GUARD: load = (guard_q == LAST) && !tx_busy;
                SEQ_SEND:  load = tx_frame_end && (cnt_q != 4'd1);
                default:   load = 1'b0;
            endcase
        end
        result_ready = (seq_q == SEQ_READY) && !start;
    end

    assign result  = result_q;
    assign outchan = tx_line;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk        (clk),
        .reset      (reset),
        .abort_i    (start),
        .load_i     (load),
        .byte_i     (chars_q[0]),
        .busy_o     (tx_busy),
        .frame_end_o(tx_frame_end),
        .line_o     (tx_line)
    );

endmodule

// File: tb/tb_outchars12_uart_tx.sv
// Directed bench for outchars12_uart_tx with CLKS_PER_BIT=4: table of transfers plus
// hand sequences for handshake, abort and reset corner cases.
module tb_outchars12_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] n;
    logic [7:0] c [12];
    logic       outchan, result, result_ready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int              nn;
        logic [11:0][7:0] ch;
        int              nbytes;
        int              done;
    } vec_t;

    vec_t vt [5];

    always #5 clk = ~clk;

    outchars12_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .start(start), .n(n),
        .c0(c[0]), .c1(c[1]), .c2(c[2]), .c3(c[3]), .c4(c[4]), .c5(c[5]),
        .c6(c[6]), .c7(c[7]), .c8(c[8]), .c9(c[9]), .c10(c[10]), .c11(c[11]),
        .outchan(outchan), .result(result), .result_ready(result_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues start over one edge, then scrambles n/c* to prove the snapshot.
    task automatic kick(input int nn, input logic [11:0][7:0] ch);
        @(negedge clk);
        start = 1'b1;
        n = 4'(nn);
        for (int i = 0; i < 12; i++) c[i] = ch[i];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 4'd7;
        for (int i = 0; i < 12; i++) c[i] = ~c[i];
    endtask

    // Sample index i is taken just after edge i following the start edge (edge 0).
    task automatic run_check(input string tag, input logic [11:0][7:0] ch,
                             input int nbytes, input int exp_done);
        logic smp [$];
        int   done_at = -1;
        int   budget = CPB * (1 + 10 * 12) + 40;
        int   bad;
        logic [9:0] frame;
        logic [7:0] dec;
        for (int i = 0; i < budget && done_at < 0; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            smp.push_back(outchan);
            if (result_ready) done_at = i;
        end
        check({tag, " done_at"}, done_at, exp_done);
        check({tag, " result"}, {31'd0, result}, 32'd1);
        bad = 0;
        for (int i = 0; i < CPB && i < smp.size(); i++) if (smp[i] !== 1'b1) bad++;
        check({tag, " guard_high"}, bad, 0);
        for (int k = 0; k < nbytes; k++) begin
            frame = {1'b1, ch[k], 1'b0};
            bad = 0;
            for (int j = 0; j < 10; j++)
                for (int t = 0; t < CPB; t++) begin
                    int idx = CPB * (1 + 10 * k + j) + t;
                    if (idx >= smp.size() || smp[idx] !== frame[j]) bad++;
                end
            check($sformatf("%s frame%0d timing", tag, k), bad, 0);
            dec = '0;
            for (int j = 0; j < 8; j++) begin
                int mid = CPB * (1 + 10 * k + 1 + j) + CPB / 2;
                if (mid < smp.size()) dec[j] = smp[mid];
            end
            check($sformatf("%s byte%0d", tag, k), dec, ch[k]);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (outchan !== 1'b1 || result_ready !== 1'b1 || result !== 1'b1) bad++;
        end
        check({tag, " quiescent"}, bad, 0);
    endtask

    initial begin
        logic [11:0][7:0] abc;
        logic [11:0][7:0] z;
        int bad;

        vt[0].nn = 1;  vt[0].ch = '0; vt[0].ch[0] = 8'h41; vt[0].nbytes = 1;  vt[0].done = 44;
        vt[1].nn = 5;  vt[1].ch = '0;
        vt[1].ch[0] = 8'h31; vt[1].ch[1] = 8'h32; vt[1].ch[2] = 8'h33;
        vt[1].ch[3] = 8'h0D; vt[1].ch[4] = 8'h0A; vt[1].nbytes = 5;  vt[1].done = 204;
        // n=0: ready is already up at the first sample after the start edge.
        vt[2].nn = 0;  vt[2].ch = '0; vt[2].ch[0] = 8'h55; vt[2].nbytes = 0;  vt[2].done = 0;
        vt[3].nn = 15;
        for (int i = 0; i < 12; i++) vt[3].ch[i] = 8'(8'h30 + i);
        vt[3].nbytes = 12; vt[3].done = 484;
        vt[4].nn = 2;  vt[4].ch = '0; vt[4].ch[0] = 8'h00; vt[4].ch[1] = 8'hFF;
        vt[4].nbytes = 2;  vt[4].done = 84;

        reset = 1'b1;
        start = 1'b0;
        n = '0;
        for (int i = 0; i < 12; i++) c[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset outchan", {31'd0, outchan}, 32'd1);
        check("reset result", {31'd0, result}, 32'd0);
        check("reset result_ready", {31'd0, result_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            kick(vt[v].nn, vt[v].ch);
            run_check($sformatf("vec%0d", v), vt[v].ch, vt[v].nbytes, vt[v].done);
        end

        // Handshake: ready drops combinationally while start is high in READY.
        @(negedge clk);
        start = 1'b1;
        n = 4'd0;
        #1;
        check("ready low during start", {31'd0, result_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("ready after n0 start", {31'd0, result_ready}, 32'd1);

        // Abort during DATA of the second byte, then a single 0x5A frame.
        abc = '0;
        abc[0] = 8'h41; abc[1] = 8'h42; abc[2] = 8'h43;
        kick(3, abc);
        repeat (55) @(negedge clk);
        #1;
        check("busy before abort", {31'd0, result_ready}, 32'd0);
        z = '0;
        z[0] = 8'h5A;
        kick(1, z);
        run_check("abort", z, 1, 44);

        // Asynchronous reset in the middle of a start bit.
        kick(2, abc);
        repeat (5) @(negedge clk);
        #1;
        check("line low in startbit", {31'd0, outchan}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async reset outchan", {31'd0, outchan}, 32'd1);
        check("async reset result", {31'd0, result}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Start and reset on the same edge: reset wins, nothing is sent.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        n = 4'd1;
        c[0] = 8'h00;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 3 * 10 * CPB; i++) begin
            @(negedge clk);
            #1;
            if (outchan !== 1'b1 || result_ready !== 1'b1 || result !== 1'b0) bad++;
        end
        check("start with reset ignored", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/outchars12_uart_tx.md
Name: outchars12_uart_tx

Overview:
Downstream consumer of the decimal-formatting stage. Takes a snapshot of up to 12 byte characters (c0..c11) and a count n, and sends c0, c1 … c(n-1) in that order as 8N1 UART frames on one serial line. It returns a one-bit completion result using the same start / result_ready handshake as the formatting stage, so it drops in as that stage's character-output callee.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); the bench uses 4
MAX_CHARS, 12, number of character inputs; fixed at 12, kept only for documentation and assertions

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; inputs are latched on the edge that samples it
n  input  4  number of characters to send; values above 12 are clamped to 12
c0..c11  input  8 each  characters; c0 is sent first
outchan  output  1  UART TX line, idles high
result  output  1  1 after a completed transfer
result_ready  output  1  idle/done indicator, combinational = (state==READY) & ~start

Behaviour:
- Reset (async): state READY, outchan=1, result=0, all counters 0. result_ready=1 while start=0.
- States: READY, GUARD, STARTBIT, DATA, STOPBIT.
- Start latching, on the edge that samples start=1 (any state):
  - latch n (clamped) into cnt and c0..c11 into a 12x8 shift register; clear char index, bit index and baud counter.
  - result is cleared to 0.
  - next state is GUARD if clamped n>0, otherwise READY with result<=1.
  - outchan<=1 on that edge.
- Snapshot: upstream may change n and c* from the cycle after start without affecting the transfer.
- GUARD: outchan=1 for CLKS_PER_BIT cycles, then STARTBIT. This guarantees a clean idle gap, including when start aborts a frame mid-flight.
- STARTBIT: outchan=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits of the current character, LSB first, each held CLKS_PER_BIT cycles.
- STOPBIT: outchan=1 for CLKS_PER_BIT cycles. Then:
  - shift the character register (c1 moves to c0) and decrement cnt.
  - if cnt becomes 0: go to READY and set result<=1.
  - otherwise go to STARTBIT with no idle gap between frames.
- Latency: result_ready rises exactly CLKS_PER_BIT*(1+10*n) cycles after the start edge for n>0, and 1 cycle after it for n=0.
- Baud counter: width clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps with no drift. Every bit boundary lands on a multiple of CLKS_PER_BIT from the start edge.
- Timing: outchan is registered, so there is no combinational path from inputs to outchan.
- Boundary cases:
  - start while busy: abort and restart. A partial frame is truncated; the GUARD period separates it from the new one.
  - start and reset together: reset wins.
  - n=13..15 is treated as 12.
  - result_ready is 0 during the start cycle even when in READY.
- Quiescence: in READY, outchan holds 1 and result holds its value until the next start or reset.

Decomposition:
- Shared package: state encoding constants (READY/GUARD/STARTBIT/DATA/STOPBIT), the default CLKS_PER_BIT for the board clock, and UART frame constants (8 data bits, 1 stop bit).
- One natural sub-module, uart_tx_byte. It is a single-frame serializer (byte in, load strobe, busy out, line out, parameter CLKS_PER_BIT). The top level then only sequences characters, clamps the count and runs the GUARD counter.

Test Plan:
- After reset, with CLKS_PER_BIT=4: outchan=1, result=0, result_ready=1. Assert reset mid-frame -> outchan returns to 1 asynchronously and result=0.
- Single character: n=1, c0=8'h41 -> line shows 4 high, then 0, then bits 1,0,0,0,0,0,1,0 and a stop bit of 1, each 4 cycles. result_ready rises 44 cycles after the start edge with result=1.
- Formatted number: n=5, c0..c4='1','2','3',8'h0D,8'h0A -> decoded bytes 31 32 33 0D 0A with no gaps between frames. Done 204 cycles after start. Changing c* one cycle after start does not alter the output.
- Empty and clamped counts: n=0 -> no falling edge on outchan, result_ready=1 one cycle after start. n=15 with c0..c11 = 8'h30..8'h3B -> exactly 12 bytes, done at 4*121=484 cycles.
- Abort: start n=3 and, during DATA of the 2nd byte, start again with n=1, c0=8'h5A -> line goes high for at least 4 cycles, then one clean 8'h5A frame. Completion is 44 cycles after the second start.
- Handshake: while start=1 in READY, result_ready=0. A bit-timing checker with CLKS_PER_BIT=7 sees every transition on 7-cycle boundaries across 10 bytes.
